// File: rtl/mtr_pkg.sv
// Shared types, default parameters and the speed-to-magnitude helper for the motor drive.
package mtr_pkg;

  typedef enum logic [1:0] {RUN, DECEL, DEAD} mtr_state_t;

  localparam int unsigned PWM_W_DEF        = 10;
  localparam int unsigned STEP_DEF         = 16;
  localparam int unsigned DEAD_PERIODS_DEF = 1;
  localparam int unsigned SPD_W            = 11;

  // -1024 negates to 1024 in SPD_W unsigned bits, so the clamp catches it.
  function automatic logic [SPD_W-1:0] sat_mag(input logic signed [SPD_W-1:0] spd,
                                               input logic [SPD_W-1:0]        max_mag);
    logic [SPD_W-1:0] mag;
    mag = spd[SPD_W-1] ? -spd : spd;
    return (mag > max_mag) ? max_mag : mag;
  endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// Command and bridge-drive bundle between the PID stage, mtr_drv and the H-bridges.
interface mtr_drv_if;
  import mtr_pkg::*;

  logic                    moving;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    lft_in1;
  logic                    lft_in2;
  logic                    rght_in1;
  logic                    rght_in2;
  logic                    pwm_sync;

  modport master (
    output moving, lft_spd, rght_spd,
    input  lft_in1, lft_in2, rght_in1, rght_in2, pwm_sync
  );

  modport slave (
    input  moving, lft_spd, rght_spd,
    output lft_in1, lft_in2, rght_in1, rght_in2, pwm_sync
  );

endinterface

// File: rtl/mtr_side.sv
// One wheel: slew-limited duty, safe reversal FSM and registered bridge drive.
// MTR_BRAKE_EN: when defined, a stopped side with moving low shorts the bridge (in1=in2=1).
//
// state | meaning
// RUN   | driving in dir_q, duty slewing toward target magnitude
// DECEL | reversal requested, duty ramping down to zero
// DEAD  | both bridge inputs low for dead_cnt periods before taking new dir
module mtr_side
  import mtr_pkg::*;
#(
  parameter int unsigned PWM_W        = PWM_W_DEF,
  parameter int unsigned STEP         = STEP_DEF,
  parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    boundary,
  input  logic [PWM_W-1:0]        cnt,
  input  logic                    moving,
  input  logic signed [SPD_W-1:0] spd,
  output logic                    in1,
  output logic                    in2
);

  localparam int unsigned      DC_W    = $clog2(DEAD_PERIODS + 1);
  localparam logic [PWM_W:0]   STEP_X  = (PWM_W+1)'(STEP);
  localparam logic [SPD_W-1:0] MAG_MAX = SPD_W'((2**PWM_W) - 1);
  localparam logic [DC_W-1:0]  DC_INIT = DC_W'(DEAD_PERIODS);

  mtr_state_t        state_q, state_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [DC_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic              in1_q, in1_d;
  logic              in2_q, in2_d;

  logic [PWM_W-1:0]  mag;
  logic              tdir;
  logic [PWM_W:0]    duty_x, mag_x, ramp, dec;
  logic              on;

`ifdef MTR_BRAKE_EN
  logic              brake_q, brake_d;
`endif

  always_comb begin
    mag    = moving ? PWM_W'(sat_mag(spd, MAG_MAX)) : '0;
    tdir   = (moving && (spd != '0)) ? spd[SPD_W-1] : dir_q;
    duty_x = {1'b0, duty_q};
    mag_x  = {1'b0, mag};
    // One extra bit keeps duty+STEP and mag+STEP from wrapping before the clamp.
    if (duty_x < mag_x) begin
      ramp = ((duty_x + STEP_X) > mag_x) ? mag_x : (duty_x + STEP_X);
    end else begin
      ramp = (duty_x < (mag_x + STEP_X)) ? mag_x : (duty_x - STEP_X);
    end
    dec = (duty_x <= STEP_X) ? '0 : (duty_x - STEP_X);
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    if (boundary) begin
      unique case (state_q)
        RUN: begin
          if (tdir == dir_q) begin
            duty_d = PWM_W'(ramp);
          end else if (duty_q != '0) begin
            duty_d  = PWM_W'(dec);
            state_d = DECEL;
          end else begin
            state_d    = DEAD;
            dead_cnt_d = DC_INIT;
          end
        end
        DECEL: begin
          if (tdir == dir_q) begin
            state_d = RUN;
            duty_d  = PWM_W'(ramp);
          end else begin
            duty_d = PWM_W'(dec);
            if (dec == '0) begin
              state_d    = DEAD;
              dead_cnt_d = DC_INIT;
            end
          end
        end
        DEAD: begin
          if (dead_cnt_q <= DC_W'(1)) begin
            dead_cnt_d = '0;
            dir_d      = tdir;
            duty_d     = '0;
            state_d    = RUN;
          end else begin
            dead_cnt_d = dead_cnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    on    = (duty_q > cnt);
    in1_d = (state_q != DEAD) && !dir_q && on;
    in2_d = (state_q != DEAD) &&  dir_q && on;
`ifdef MTR_BRAKE_EN
    brake_d = brake_q;
    if (boundary) begin
      brake_d = !moving && (state_q == RUN) && (duty_q == '0);
    end
    if (brake_q && (state_q != DEAD)) begin
      in1_d = 1'b1;
      in2_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      dead_cnt_q <= '0;
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      dead_cnt_q <= dead_cnt_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
    end
  end

`ifdef MTR_BRAKE_EN
  always_ff @(posedge clk) begin
    if (rst) brake_q <= 1'b0;
    else     brake_q <= brake_d;
  end
`endif

  assign in1 = in1_q;
  assign in2 = in2_q;

endmodule

// File: rtl/mtr_drv.sv
// Two-wheel motor drive: shared PWM counter, period boundary decode and pwm_sync.
// MTR_BRAKE_EN (see mtr_side) enables dynamic braking on stopped sides.
module mtr_drv
  import mtr_pkg::*;
#(
  parameter int unsigned PWM_W        = PWM_W_DEF,
  parameter int unsigned STEP         = STEP_DEF,
  parameter int unsigned DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mtr_drv_if.slave   bus
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             pwm_sync_q, pwm_sync_d;
  logic             boundary;

  // Last cycle of a period: commands are sampled here and take effect at cnt==0.
  always_comb begin
    boundary   = (cnt_q == '1);
    cnt_d      = cnt_q + 1'b1;
    pwm_sync_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pwm_sync_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end

  assign bus.pwm_sync = pwm_sync_q;

  mtr_side #(.PWM_W(PWM_W), .STEP(STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_lft (
    .clk      (clk),
    .rst      (rst),
    .boundary (boundary),
    .cnt      (cnt_q),
    .moving   (bus.moving),
    .spd      (bus.lft_spd),
    .in1      (bus.lft_in1),
    .in2      (bus.lft_in2)
  );

  mtr_side #(.PWM_W(PWM_W), .STEP(STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_rght (
    .clk      (clk),
    .rst      (rst),
    .boundary (boundary),
    .cnt      (cnt_q),
    .moving   (bus.moving),
    .spd      (bus.rght_spd),
    .in1      (bus.rght_in1),
    .in2      (bus.rght_in2)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-period high-time counts per bridge input against a period-level model.
module tb_mtr_drv;
  import mtr_pkg::*;

  localparam int PWM_W  = 10;
  localparam int STEP   = 16;
  localparam int DP     = 1;
  localparam int PERIOD = 1 << PWM_W;
  localparam int MAXD   = PERIOD - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mtr_drv_if bus ();

  mtr_drv #(.PWM_W(PWM_W), .STEP(STEP), .DEAD_PERIODS(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-side model: duty level, reverse flag, slowing-for-reversal flag, dead periods left.
  int m_duty [2];
  int m_rev  [2];
  int m_slow [2];
  int m_dead [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_duty[s] = 0;
      m_rev[s]  = 0;
      m_slow[s] = 0;
      m_dead[s] = 0;
    end
  endtask

  task automatic model_step(input int s, input bit mv, input int spd);
    int mag;
    int want_rev;
    mag = (spd < 0) ? -spd : spd;
    if (mag > MAXD) mag = MAXD;
    if (!mv) mag = 0;
    want_rev = (mv && spd != 0) ? int'(spd < 0) : m_rev[s];
    if (m_dead[s] > 0) begin
      m_dead[s]--;
      if (m_dead[s] == 0) begin
        m_rev[s]  = want_rev;
        m_duty[s] = 0;
      end
    end else if (want_rev == m_rev[s]) begin
      m_slow[s] = 0;
      if (m_duty[s] < mag) m_duty[s] = (m_duty[s] + STEP > mag) ? mag : m_duty[s] + STEP;
      else                 m_duty[s] = (m_duty[s] - STEP < mag) ? mag : m_duty[s] - STEP;
    end else if (!m_slow[s] && m_duty[s] == 0) begin
      m_dead[s] = DP;
    end else begin
      m_duty[s] = (m_duty[s] > STEP) ? m_duty[s] - STEP : 0;
      if (m_slow[s] && m_duty[s] == 0) begin
        m_dead[s] = DP;
        m_slow[s] = 0;
      end else begin
        m_slow[s] = 1;
      end
    end
  endtask

  function automatic int rnd_spd();
    if ($urandom_range(0, 7) == 0) return -1024;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  task automatic do_reset(input string tag);
    logic [4:0] outs;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    outs = {bus.lft_in1, bus.lft_in2, bus.rght_in1, bus.rght_in2, bus.pwm_sync};
    check($sformatf("%s_outs", tag), {27'd0, outs}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Output window of one period: cnt_q 1..PERIOD-1 then 0 of the next, due to the output register.
  task automatic run_period(input string tag, input bit mv, input int l, input int r);
    int   hi1 [2];
    int   hi2 [2];
    int   e1  [2];
    int   e2  [2];
    int   both;
    int   sync_n;
    logic sync_last;
    for (int s = 0; s < 2; s++) begin
      e1[s]  = (m_dead[s] == 0 && m_rev[s] == 0) ? m_duty[s] : 0;
      e2[s]  = (m_dead[s] == 0 && m_rev[s] == 1) ? m_duty[s] : 0;
      hi1[s] = 0;
      hi2[s] = 0;
    end
    both      = 0;
    sync_n    = 0;
    sync_last = 1'b0;
    bus.moving   = mv;
    bus.lft_spd  = 11'(l);
    bus.rght_spd = 11'(r);
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk);
      #1;
      hi1[0] += int'(bus.lft_in1);
      hi2[0] += int'(bus.lft_in2);
      hi1[1] += int'(bus.rght_in1);
      hi2[1] += int'(bus.rght_in2);
      if ((bus.lft_in1 && bus.lft_in2) || (bus.rght_in1 && bus.rght_in2)) both++;
      if (bus.pwm_sync) sync_n++;
      sync_last = bus.pwm_sync;
    end
    check($sformatf("%s_lft_in1", tag),  hi1[0], e1[0]);
    check($sformatf("%s_lft_in2", tag),  hi2[0], e2[0]);
    check($sformatf("%s_rght_in1", tag), hi1[1], e1[1]);
    check($sformatf("%s_rght_in2", tag), hi2[1], e2[1]);
    check($sformatf("%s_both_hi", tag),  both, 0);
    check($sformatf("%s_sync_n", tag),   sync_n, 1);
    check($sformatf("%s_sync_pos", tag), {31'd0, sync_last}, 1);
    model_step(0, mv, l);
    model_step(1, mv, r);
  endtask

  initial begin
    bus.moving   = 1'b0;
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    model_reset();

    do_reset("por");

    for (int k = 0; k < 8; k++)  run_period("up100",   1'b1, 100,  rnd_spd());
    for (int k = 0; k < 7; k++)  run_period("up200",   1'b1, 200,  rnd_spd());
    for (int k = 0; k < 3; k++)  run_period("rev_try", 1'b1, -200, rnd_spd());
    for (int k = 0; k < 4; k++)  run_period("abort",   1'b1, 200,  rnd_spd());
    for (int k = 0; k < 18; k++) run_period("reverse", 1'b1, -200, rnd_spd());
    for (int k = 0; k < 6; k++)  run_period("coast",   1'b0, -200, rnd_spd());

    do_reset("rst2");
    for (int k = 0; k < 21; k++) run_period("neg_full", 1'b1, -1024, 300);

    // Partway into a period: confirm both sides drive, then reset at cnt==500.
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk);
      #1;
      if (i == 100) begin
        check("pre_rst_rght_in1", {31'd0, bus.rght_in1},
              (m_dead[1] == 0 && m_rev[1] == 0 && m_duty[1] > 99) ? 1 : 0);
        check("pre_rst_lft_in2", {31'd0, bus.lft_in2},
              (m_dead[0] == 0 && m_rev[0] == 1 && m_duty[0] > 99) ? 1 : 0);
      end
    end
    do_reset("mid_rst");

    for (int k = 0; k < 4; k++) run_period("restart", 1'b1, -1024, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
